uart_echo_buf: RTL and testbench

- Parametrised successor to the single-byte UART loopback glue.
- Sits between `uart_m` receive outputs (`bytercvd`, `q`) and transmit inputs (`load`, `d`, `txbusy`).
- Buffers received words in a FIFO and retransmits them through a transmit handshake FSM, with a runtime-selectable transform.
- Reports FIFO level, sticky overflow and a dropped-word count for LED/debug pins.

---
 rtl/uart_echo_buf.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_echo_buf.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_buf.sv
// rtl/uart_echo_buf.sv - FIFO-buffered UART echo with selectable transform and drop accounting
//
// Purpose:
//   Sits between the UART receive outputs and transmit inputs. Received words
//   are queued in a circular FIFO. A transmit handshake FSM pops the head,
//   transforms it per `mode`, registers it into `d` and pulses `load`. Words
//   lost to a full FIFO or to a transmitter that never acknowledges are
//   counted for debug pins.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   bytercvd  in   one-cycle strobe, `q` holds a received word
//   q         in   received word
//   txbusy    in   UART transmitter busy
//   load      out  one-cycle strobe to start transmitting `d` (registered)
//   d         out  word to transmit (registered)
//   mode      in   00 verbatim, 01 ASCII case swap, 10 invert, 11 sink
//   clr       in   synchronous clear of overflow and dropcnt
//   level     out  FIFO occupancy, 0..2**DEPTH_LOG2
//   overflow  out  sticky: a word arrived while the FIFO was full
//   dropcnt   out  saturating count of words dropped (full FIFO or ack timeout)

module uart_echo_buf #(
  parameter int WIDTH       = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 3,
  parameter int DROPCNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bytercvd,
  input  logic [WIDTH-1:0]     q,
  input  logic                 txbusy,
  output logic                 load,
  output logic [WIDTH-1:0]     d,
  input  logic [1:0]           mode,
  input  logic                 clr,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 overflow,
  output logic [DROPCNT_W-1:0] dropcnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]       TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [DEPTH_LOG2:0]   PTR_ONE = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [DEPTH_LOG2:0]    wp_q, wp_d;
  logic [DEPTH_LOG2:0]    rp_q, rp_d;
  logic [DEPTH_LOG2:0]    level_q, level_d;
  logic [TO_W-1:0]        tcnt_q, tcnt_d;
  logic                   load_q, load_d;
  logic [WIDTH-1:0]       d_q, d_d;
  logic                   ovf_q, ovf_d;
  logic [DROPCNT_W-1:0]   dcnt_q, dcnt_d;

  logic [WIDTH-1:0]       mem [DEPTH];

  logic                   full, empty;
  logic                   push, pop;
  logic                   drop_full, drop_to;
  logic [WIDTH-1:0]       head, head_swap, head_xf;
  logic [1:0]             n_drop;
  logic [DROPCNT_W-1:0]   dcnt_base;
  logic [DROPCNT_W:0]     dcnt_sum;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2]) &&
                 (wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0]);
  assign empty = (wp_q == rp_q);

  // Full is judged on pre-cycle state: a same-cycle pop does not make room.
  assign push      = bytercvd && !full;
  assign drop_full = bytercvd && full;

  assign head = mem[rp_q[DEPTH_LOG2-1:0]];

  // ---------------------------------------------------------------------------
  // Transform of the FIFO head, applied at pop time
  // ---------------------------------------------------------------------------
  if (WIDTH == 8) begin : g_case8
    always_comb begin
      head_swap = head;
      if ((head >= 8'h41 && head <= 8'h5A) || (head >= 8'h61 && head <= 8'h7A)) begin
        head_swap = head ^ 8'h20;
      end
    end
  end else begin : g_nocase
    assign head_swap = head;
  end

  always_comb begin
    head_xf = head;
    case (mode)
      2'b01:   head_xf = head_swap;
      2'b10:   head_xf = ~head;
      default: head_xf = head;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage: no reset, contents are meaningless until written
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp_q[DEPTH_LOG2-1:0]] <= q;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!empty && !txbusy) begin
          // Sink mode consumes the word without handing it to the UART.
          state_d = (mode == 2'b11) ? S_IDLE : S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (txbusy) begin
          state_d = S_WAIT_LO;
        end else if (tcnt_q == TO_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_LO: begin
        if (!txbusy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    pop     = (state_q == S_IDLE) && !empty && !txbusy;
    drop_to = (state_q == S_WAIT_HI) && !txbusy && (tcnt_q == TO_LAST);
    d_d     = pop ? head_xf : d_q;
    // load is registered so it is high exactly while the FSM sits in LOAD.
    load_d  = (state_d == S_LOAD);

    tcnt_d = tcnt_q;
    if (state_q == S_LOAD) begin
      tcnt_d = '0;
    end else if (state_q == S_WAIT_HI && !txbusy && tcnt_q != TO_LAST) begin
      tcnt_d = tcnt_q + TO_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, level and drop accounting
  // ---------------------------------------------------------------------------
  always_comb begin
    wp_d    = push ? (wp_q + PTR_ONE) : wp_q;
    rp_d    = pop  ? (rp_q + PTR_ONE) : rp_q;
    level_d = wp_d - rp_d;

    // A full-FIFO drop and an ack timeout can coincide, so up to two events.
    n_drop    = {1'b0, drop_full} + {1'b0, drop_to};
    dcnt_base = clr ? '0 : dcnt_q;
    dcnt_sum  = {1'b0, dcnt_base} + (DROPCNT_W + 1)'(n_drop);
    dcnt_d    = dcnt_sum[DROPCNT_W] ? '1 : dcnt_sum[DROPCNT_W-1:0];

    // clr wins over a same-cycle overflow.
    ovf_d = clr ? 1'b0 : (ovf_q || drop_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      tcnt_q  <= '0;
      load_q  <= 1'b0;
      d_q     <= '0;
      ovf_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      tcnt_q  <= tcnt_d;
      load_q  <= load_d;
      d_q     <= d_d;
      ovf_q   <= ovf_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign load     = load_q;
  assign d        = d_q;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign dropcnt  = dcnt_q;

endmodule

// File: tb/tb_uart_echo_buf.sv
// tb/tb_uart_echo_buf.sv - self-checking bench for uart_echo_buf with a queue-based reference model

module tb_uart_echo_buf;

  localparam int W     = 8;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int ACKT  = 3;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bytercvd = 1'b0;
  logic [W-1:0]  q = '0;
  logic          txbusy = 1'b0;
  logic          load;
  logic [W-1:0]  d;
  logic [1:0]    mode = 2'b00;
  logic          clr = 1'b0;
  logic [DL:0]   level;
  logic          overflow;
  logic [DW-1:0] dropcnt;

  always #5 clk = ~clk;

  uart_echo_buf #(
    .WIDTH(W), .DEPTH_LOG2(DL), .ACK_TIMEOUT(ACKT), .DROPCNT_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bytercvd(bytercvd), .q(q), .txbusy(txbusy),
    .load(load), .d(d), .mode(mode), .clr(clr), .level(level),
    .overflow(overflow), .dropcnt(dropcnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: FIFO as a queue, transmitter path as "free / load shown /
  // awaiting ack with a budget / awaiting release".
  // ---------------------------------------------------------------------------
  logic [W-1:0] mq[$];
  bit           m_ld = 0, m_wack = 0, m_wrel = 0;
  int           m_ackleft = 0;
  logic [W-1:0] m_d = '0;
  int           m_ovf = 0, m_dcnt = 0;
  bit           mfull, mdrop, mpop, mtmo;
  int           mn;
  logic [W-1:0] mhead;

  function automatic logic [7:0] xf(input logic [7:0] w, input logic [1:0] m);
    if (m == 2'b10) return ~w;
    if (m == 2'b01 && ((w >= 8'h41 && w <= 8'h5A) || (w >= 8'h61 && w <= 8'h7A)))
      return w ^ 8'h20;
    return w;
  endfunction

  function automatic bit m_idle();
    return !m_ld && !m_wack && !m_wrel && mq.size() == 0;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ld = 0; m_wack = 0; m_wrel = 0; m_ackleft = 0;
      m_d = '0; m_ovf = 0; m_dcnt = 0;
    end else begin
      mfull = (mq.size() == DEPTH);
      mdrop = bytercvd && mfull;
      mtmo  = 0;
      mpop  = !(m_ld || m_wack || m_wrel) && mq.size() != 0 && !txbusy;
      if (m_ld) begin
        m_ld = 0; m_wack = 1; m_ackleft = ACKT;
      end else if (m_wack) begin
        if (txbusy) begin
          m_wack = 0; m_wrel = 1;
        end else begin
          m_ackleft--;
          if (m_ackleft == 0) begin m_wack = 0; mtmo = 1; end
        end
      end else if (m_wrel) begin
        if (!txbusy) m_wrel = 0;
      end else if (mpop) begin
        mhead = mq.pop_front();
        m_d   = (mode == 2'b11) ? mhead : xf(mhead, mode);
        m_ld  = (mode != 2'b11);
      end
      if (bytercvd && !mfull) mq.push_back(q);
      mn     = int'(mdrop) + int'(mtmo);
      m_dcnt = clr ? mn : m_dcnt + mn;
      if (m_dcnt > 255) m_dcnt = 255;
      m_ovf  = clr ? 0 : (m_ovf | int'(mdrop));
    end
  end

  // ---------------------------------------------------------------------------
  // UART transmitter stand-in: busy for busy_len cycles starting the cycle
  // after load (busy_len==0 means it never acknowledges).
  // ---------------------------------------------------------------------------
  int busy_len = 10;
  int busy_cnt = 0;
  bit force_busy = 0;
  bit saw_ld;

  initial forever begin
    @(posedge clk);
    cyc++;
    saw_ld = load;
    #1;
    if (busy_cnt > 0) busy_cnt--;
    if (saw_ld && busy_len > 0) busy_cnt = busy_len;
    txbusy = force_busy || busy_cnt > 0;
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model; also logs transmitted words.
  // ---------------------------------------------------------------------------
  logic [W-1:0] sent[$];

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("load", load, m_ld);
      chk("d", d, m_d);
      chk("level", level, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("dropcnt", dropcnt, m_dcnt);
      if (load) sent.push_back(d);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic strobe(input logic [7:0] w);
    bytercvd = 1'b1; q = w;
    tick();
    bytercvd = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (!m_idle() && k < 600) begin tick(); k++; end
    chk({nm, "_idle_timeout"}, (k < 600), 1);
  endtask

  logic [7:0] exp_t2 [4] = '{8'h41, 8'h7A, 8'h31, 8'h7B};
  logic [7:0] in_t2  [4] = '{8'h61, 8'h5A, 8'h31, 8'h7B};
  logic [7:0] inq[$];

  initial begin
    int t0, lc, base, k;
    logic [7:0] w;

    tick(3);
    rst_n = 1'b1;
    at_neg();
    chk("rst_load", load, 0);
    chk("rst_d", d, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropcnt", dropcnt, 0);

    // Single word, verbatim: load in the third cycle counting the strobe cycle.
    tick();
    mode = 2'b00; busy_len = 10;
    t0 = cyc;
    strobe(8'h41);
    at_neg();
    chk("t1_level_one", level, 1);
    lc = -1;
    for (int i = 0; i < 20; i++) begin
      at_neg();
      if (load) begin lc = cyc; break; end
    end
    chk("t1_load_cycle", lc - t0 + 1, 3);
    chk("t1_d", d, 8'h41);
    wait_idle("t1");
    chk("t1_level_zero", level, 0);
    chk("t1_loads", sent.size(), 1);

    // Case swap.
    mode = 2'b01;
    for (int i = 0; i < 4; i++) begin strobe(in_t2[i]); tick(2); end
    wait_idle("t2");
    chk("t2_count", sent.size(), 5);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_word%0d", i), sent[1+i], exp_t2[i]);

    // Fill past full while the UART is busy.
    mode = 2'b00;
    force_busy = 1; tick(2);
    for (int i = 0; i < 18; i++) strobe(8'(i));
    at_neg();
    chk("t3_level", level, 16);
    chk("t3_overflow", overflow, 1);
    chk("t3_dropcnt", dropcnt, 2);
    force_busy = 0;
    wait_idle("t3");
    chk("t3_count", sent.size(), 21);
    for (int i = 0; i < 16; i++) chk($sformatf("t3_word%0d", i), sent[5+i], 8'(i));
    clr = 1'b1; tick(); clr = 1'b0;
    at_neg();
    chk("t3_clr_overflow", overflow, 0);
    chk("t3_clr_dropcnt", dropcnt, 0);

    // UART never acknowledges: one timeout, then normal service resumes.
    tick();
    busy_len = 0;
    strobe(8'h55);
    wait_idle("t4a");
    chk("t4_dropcnt", dropcnt, 1);
    chk("t4_loads", sent.size(), 22);
    busy_len = 10;
    strobe(8'h66);
    wait_idle("t4b");
    chk("t4_next_count", sent.size(), 23);
    chk("t4_next_word", sent[22], 8'h66);
    chk("t4_dropcnt_hold", dropcnt, 1);

    // Sink mode, then invert.
    clr = 1'b1; tick(); clr = 1'b0;
    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin strobe(8'($urandom)); tick($urandom_range(0, 2)); end
    wait_idle("t5a");
    chk("t5_no_load", sent.size(), 23);
    chk("t5_level", level, 0);
    chk("t5_dropcnt", dropcnt, 0);
    mode = 2'b10;
    strobe(8'h0F);
    wait_idle("t5b");
    chk("t5_inv_word", sent[23], 8'hF0);
    chk("t5_inv_d", d, 8'hF0);

    // Streaming across pointer wraps, then reset mid-WAIT_LO.
    mode = 2'b00; busy_len = 3;
    base = sent.size();
    for (int i = 0; i < 40; i++) begin
      w = 8'($urandom);
      inq.push_back(w);
      strobe(w);
      tick($urandom_range(1, 8));
    end
    k = 0;
    while (!(sent.size() == base + 40 && m_wrel && txbusy) && k < 600) begin tick(); k++; end
    chk("t6_reach_wait_lo", (k < 600), 1);
    chk("t6_count", sent.size(), base + 40);
    for (int i = 0; i < 40 && base + i < sent.size(); i++)
      chk($sformatf("t6_word%0d", i), sent[base+i], inq[i]);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_load", load, 0);
    chk("t6_rst_d", d, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_dropcnt", dropcnt, 0);
    #1 rst_n = 1'b1;
    tick();

    // Randomised mix of modes, ack behaviour, clears and arrival patterns.
    for (int i = 0; i < 300; i++) begin
      mode     = 2'($urandom_range(0, 3));
      if ((i % 20) == 0) busy_len = $urandom_range(0, 3);
      clr      = ($urandom_range(0, 15) == 0);
      bytercvd = $urandom_range(0, 1);
      q        = 8'($urandom);
      tick();
    end
    bytercvd = 1'b0; clr = 1'b0;
    wait_idle("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
